serial_frame_rx: RTL and testbench

Asynchronous-style serial frame receiver that reassembles parallel words from a single-bit line driven by the team's shift-register transmitter. It sits at the input edge of the design. It synchronises the line into the CLK_signal domain, detects start bits, samples mid-bit, optionally checks even parity, and presents each word on a one-entry valid/ready output buffer. Downstream logic consumes words through that handshake.

---
 rtl/serial_frame_pkg.sv | 38 +++
 rtl/serial_frame_rx_sync_2ff.sv | 32 +++
 rtl/serial_frame_rx.sv | 199 +++++++++++++++++++
 tb/tb_serial_frame_rx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
//==============================================================================
// Module      : serial_frame_pkg
// Description : Shared types and helpers for the serial frame receiver/transmitter.
// Revision    : 1.0
//==============================================================================
`default_nettype none

package serial_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef SERIAL_FRAME_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } rx_state_t;

    // The start bit is sampled half a bit period after the edge so that
    // every later sample lands mid-bit.
    localparam int C_HALF_BIT_DIV = 2;

    // Widest frame either side of the link supports.
    localparam int C_MAX_WIDTH = 9;

    function automatic int half_bit_reload(input int clks_per_bit);
        return clks_per_bit / C_HALF_BIT_DIV - 1;
    endfunction

    // Even parity over a zero-extended word.
    function automatic logic even_parity(input logic [C_MAX_WIDTH-1:0] data);
        return ^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_frame_rx_sync_2ff.sv
//==============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser, resets to 1 (idle level of a serial line).
// Revision    : 1.0
//==============================================================================
`default_nettype none

module sync_2ff (
    input  logic CLK_signal,
    input  logic RESET,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge CLK_signal) begin
        if (RESET) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/serial_frame_rx.sv
//==============================================================================
// Module      : serial_frame_rx
// Description : Serial frame receiver with a one-entry valid/ready output buffer.
//               Define SERIAL_FRAME_RX_PARITY_EN to add an even-parity bit.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             CLK_signal,
    input  logic             RESET,
    input  logic             SERIAL_IN,
    input  logic             DATA_READY,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             DATA_VALID,
    output logic             FRAME_ERR,
    output logic             OVERRUN,
    output logic             PARITY_ERR,
    output logic             BUSY
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] C_HALF_RELOAD = CNT_W'(half_bit_reload(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] C_FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] C_LAST_IDX    = IDX_W'(WIDTH - 1);

    logic             w_rx_s;
    logic             w_fall;
    logic             w_tick_done;

    rx_state_t        state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [WIDTH-1:0] shift_q,  shift_d;
    logic [WIDTH-1:0] data_q,   data_d;
    logic             valid_q,  valid_d;
    logic             ferr_q,   ferr_d;
    logic             ovr_q,    ovr_d;
    logic             rx_prev_q;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic             pfail_q,  pfail_d;
    logic             perr_q,   perr_d;
`endif

    sync_2ff u_sync (
        .CLK_signal (CLK_signal),
        .RESET      (RESET),
        .d_i        (SERIAL_IN),
        .q_o        (w_rx_s)
    );

    assign w_fall      = rx_prev_q & ~w_rx_s;
    assign w_tick_done = (cnt_q == '0);

    always_ff @(posedge CLK_signal) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            rx_prev_q <= 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            pfail_q   <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            rx_prev_q <= w_rx_s;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            pfail_q   <= pfail_d;
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q & ~DATA_READY;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        pfail_d = pfail_q;
        perr_d  = 1'b0;
`endif

        if ((state_q != ST_IDLE) && !w_tick_done) begin
            cnt_d = cnt_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_fall) begin
                    state_d = ST_START;
                    cnt_d   = C_HALF_RELOAD;
                end
            end

            ST_START: begin
                if (w_tick_done) begin
                    if (!w_rx_s) begin
                        state_d = ST_DATA;
                        cnt_d   = C_FULL_RELOAD;
                        idx_d   = '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        pfail_d = 1'b0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_DATA: begin
                if (w_tick_done) begin
                    shift_d = {w_rx_s, shift_q[WIDTH-1:1]};
                    cnt_d   = C_FULL_RELOAD;
                    if (idx_q == C_LAST_IDX) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

`ifdef SERIAL_FRAME_RX_PARITY_EN
            ST_PARITY: begin
                if (w_tick_done) begin
                    pfail_d = even_parity(C_MAX_WIDTH'(shift_q)) ^ w_rx_s;
                    cnt_d   = C_FULL_RELOAD;
                    state_d = ST_STOP;
                end
            end
`endif

            ST_STOP: begin
                if (w_tick_done) begin
                    state_d = ST_IDLE;
                    if (!w_rx_s) begin
                        ferr_d = 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    end else if (pfail_q) begin
                        perr_d = 1'b1;
`endif
                    end else if (!valid_q || DATA_READY) begin
                        // A consumer taking the old word this cycle frees the slot.
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign DATA_OUT   = data_q;
    assign DATA_VALID = valid_q;
    assign FRAME_ERR  = ferr_q;
    assign OVERRUN    = ovr_q;
    assign BUSY       = (state_q != ST_IDLE);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    assign PARITY_ERR = perr_q;
`else
    assign PARITY_ERR = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
//==============================================================================
// Module      : tb_serial_frame_rx
// Description : Directed, table-driven bench for serial_frame_rx (WIDTH=8, CLKS_PER_BIT=4).
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_serial_frame_rx;

    localparam int C_CPB = 4;

    logic       CLK_signal = 1'b0;
    logic       RESET      = 1'b1;
    logic       SERIAL_IN  = 1'b1;
    logic       DATA_READY = 1'b0;
    logic [7:0] DATA_OUT;
    logic       DATA_VALID;
    logic       FRAME_ERR;
    logic       OVERRUN;
    logic       PARITY_ERR;
    logic       BUSY;

    int n_pass  = 0;
    int n_total = 0;

    // Event counters, written only by the monitor below.
    int         m_acc  = 0;
    int         m_ferr = 0;
    int         m_ovr  = 0;
    int         m_perr = 0;
    int         m_busy = 0;
    logic [7:0] m_last = 8'h00;

    serial_frame_rx #(
        .WIDTH        (8),
        .CLKS_PER_BIT (C_CPB)
    ) dut (
        .CLK_signal (CLK_signal),
        .RESET      (RESET),
        .SERIAL_IN  (SERIAL_IN),
        .DATA_READY (DATA_READY),
        .DATA_OUT   (DATA_OUT),
        .DATA_VALID (DATA_VALID),
        .FRAME_ERR  (FRAME_ERR),
        .OVERRUN    (OVERRUN),
        .PARITY_ERR (PARITY_ERR),
        .BUSY       (BUSY)
    );

    always #5 CLK_signal = ~CLK_signal;

    always @(negedge CLK_signal) begin
        if (DATA_VALID && DATA_READY) begin
            m_acc  = m_acc + 1;
            m_last = DATA_OUT;
        end
        m_ferr = m_ferr + int'(FRAME_ERR);
        m_ovr  = m_ovr  + int'(OVERRUN);
        m_perr = m_perr + int'(PARITY_ERR);
        m_busy = m_busy + int'(BUSY);
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       ready;
        int         exp_acc;
        logic [7:0] exp_last;
        int         exp_ferr;
        int         exp_ovr;
        logic       exp_valid;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs [6];

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK_signal);
            #1;
        end
    endtask

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input logic par_flip, input logic hold_low);
        logic pbit;
        pbit = (^data) ^ par_flip;
        SERIAL_IN = 1'b0;
        cyc(C_CPB);
        for (int i = 0; i < 8; i++) begin
            SERIAL_IN = data[i];
            cyc(C_CPB);
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        SERIAL_IN = pbit;
        cyc(C_CPB);
`endif
        SERIAL_IN = stop;
        cyc(C_CPB);
        if (!hold_low) SERIAL_IN = 1'b1;
    endtask

    int s_acc, s_ferr, s_ovr, s_perr, s_busy;

    task automatic snap();
        s_acc  = m_acc;
        s_ferr = m_ferr;
        s_ovr  = m_ovr;
        s_perr = m_perr;
        s_busy = m_busy;
    endtask

    initial begin
        //            data   stop ready acc last   ferr ovr valid dout
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1, 8'hA5, 0, 0, 1'b0, 8'h00};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1, 8'h00, 0, 0, 1'b0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1, 8'hFF, 0, 0, 1'b0, 8'h00};
        vecs[3] = '{8'h3C, 1'b0, 1'b1, 0, 8'h00, 1, 0, 1'b0, 8'h00};
        vecs[4] = '{8'h11, 1'b1, 1'b0, 0, 8'h00, 0, 0, 1'b1, 8'h11};
        vecs[5] = '{8'h22, 1'b1, 1'b0, 0, 8'h00, 0, 1, 1'b1, 8'h11};

        cyc(3);
        RESET = 1'b0;
        check("reset_valid", int'(DATA_VALID), 0);
        check("reset_dout",  int'(DATA_OUT),   0);
        check("reset_busy",  int'(BUSY),       0);
        check("reset_ferr",  int'(FRAME_ERR),  0);
        cyc(4);

        for (int v = 0; v < 6; v++) begin
            DATA_READY = vecs[v].ready;
            snap();
            send_frame(vecs[v].data, vecs[v].stop, 1'b0, 1'b0);
            cyc(12);
            check($sformatf("v%0d_accepts", v), m_acc - s_acc, vecs[v].exp_acc);
            if (vecs[v].exp_acc > 0)
                check($sformatf("v%0d_data", v), int'(m_last), int'(vecs[v].exp_last));
            if (vecs[v].ready)
                check($sformatf("v%0d_valid_cycles", v), m_acc - s_acc, vecs[v].exp_acc);
            check($sformatf("v%0d_ferr", v), m_ferr - s_ferr, vecs[v].exp_ferr);
            check($sformatf("v%0d_ovr", v),  m_ovr - s_ovr,   vecs[v].exp_ovr);
            check($sformatf("v%0d_perr", v), m_perr - s_perr, 0);
            check($sformatf("v%0d_valid", v), int'(DATA_VALID), int'(vecs[v].exp_valid));
            if (vecs[v].exp_valid)
                check($sformatf("v%0d_dout", v), int'(DATA_OUT), int'(vecs[v].exp_dout));
        end

        // Buffered 0x11 is taken once the consumer becomes ready.
        snap();
        DATA_READY = 1'b1;
        cyc(1);
        check("drain_accept", m_acc - s_acc, 1);
        check("drain_data",   int'(m_last), 8'h11);
        check("drain_valid",  int'(DATA_VALID), 0);
        cyc(4);

        // Two-cycle glitch: START for two cycles, then back to IDLE quietly.
        snap();
        SERIAL_IN = 1'b0;
        cyc(2);
        SERIAL_IN = 1'b1;
        cyc(20);
        check("glitch_busy_cycles", m_busy - s_busy, 2);
        check("glitch_accepts",     m_acc - s_acc,   0);
        check("glitch_ferr",        m_ferr - s_ferr, 0);
        check("glitch_busy_end",    int'(BUSY),      0);

        // Break: stop bit low and line held low must not retrigger.
        snap();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        cyc(4);
        check("break_ferr",   m_ferr - s_ferr, 1);
        check("break_accept", m_acc - s_acc,   0);
        snap();
        cyc(4 * C_CPB);
        check("break_no_restart", m_busy - s_busy, 0);
        SERIAL_IN = 1'b1;
        cyc(8);

`ifdef SERIAL_FRAME_RX_PARITY_EN
        snap();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        cyc(12);
        check("par_bad_perr",   m_perr - s_perr, 1);
        check("par_bad_accept", m_acc - s_acc,   0);
        snap();
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        cyc(12);
        check("par_ok_perr",   m_perr - s_perr, 0);
        check("par_ok_accept", m_acc - s_acc,   1);
        check("par_ok_data",   int'(m_last),    8'h07);
`endif

        // Reset in the middle of data bit 4 with a word already buffered.
        DATA_READY = 1'b0;
        send_frame(8'h77, 1'b1, 1'b0, 1'b0);
        cyc(12);
        check("pre_reset_valid", int'(DATA_VALID), 1);
        check("pre_reset_dout",  int'(DATA_OUT),   8'h77);
        snap();
        SERIAL_IN = 1'b0;
        cyc(C_CPB);
        for (int i = 0; i < 4; i++) begin
            SERIAL_IN = (i % 2 == 0) ? 1'b0 : 1'b1;
            cyc(C_CPB);
        end
        SERIAL_IN = 1'b1;
        cyc(2);
        RESET = 1'b1;
        cyc(1);
        RESET = 1'b0;
        check("rst_mid_valid", int'(DATA_VALID), 0);
        check("rst_mid_dout",  int'(DATA_OUT),   0);
        check("rst_mid_busy",  int'(BUSY),       0);
        check("rst_mid_pulse", int'(FRAME_ERR | OVERRUN | PARITY_ERR), 0);
        cyc(12 * C_CPB);
        check("rst_mid_no_ferr", m_ferr - s_ferr, 0);
        check("rst_mid_idle",    int'(BUSY),      0);

        snap();
        DATA_READY = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        cyc(12);
        check("post_rst_accept", m_acc - s_acc,   1);
        check("post_rst_data",   int'(m_last),    8'h5A);
        check("post_rst_ferr",   m_ferr - s_ferr, 0);
        check("post_rst_ovr",    m_ovr - s_ovr,   0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
